// File: rtl/fifo_rd_arbiter.sv
// Read-side scheduler for the async FIFO: round-robin burst grants over the single
// read port, returning each popped word registered and tagged with its owner index.
module fifo_rd_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  localparam int IDX_W     = $clog2(NUM_REQ),
  localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_rinc,
  input  logic [NUM_REQ-1:0]    req,
  output logic [NUM_REQ-1:0]    gnt,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [IDX_W-1:0]      out_id,
  output logic                  busy
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [NUM_REQ-1:0] ONE_HOT_0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0]      out_id_q, out_id_d;

  logic [IDX_W-1:0]      win_idx_s;
  logic [IDX_W:0]        sum_s;
  logic [IDX_W:0]        pos_s;
  logic                  pop_s;
  logic                  last_s;

  // Round-robin winner: scan from the highest candidate down so the index
  // closest to rr_ptr (modulo NUM_REQ, explicit for non-power-of-two) wins.
  always_comb begin
    win_idx_s = '0;
    sum_s     = '0;
    pos_s     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum_s     = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      pos_s     = (sum_s >= (IDX_W+1)'(NUM_REQ)) ? (sum_s - (IDX_W+1)'(NUM_REQ)) : sum_s;
      win_idx_s = req[pos_s[IDX_W-1:0]] ? pos_s[IDX_W-1:0] : win_idx_s;
    end
  end

  assign pop_s     = (state_q == GRANT) && req[gnt_idx_q] && !fifo_empty;
  assign last_s    = (cnt_q == CNT_W'(MAX_BURST - 1));
  assign fifo_rinc = pop_s;

  // Next-state, grant and data-return logic.
  always_comb begin
    state_d     = state_q;
    gnt_idx_d   = gnt_idx_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    out_valid_d = pop_s;
    out_data_d  = pop_s ? fifo_rdata : out_data_q;
    out_id_d    = pop_s ? gnt_idx_q : out_id_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && (|req)) begin
          state_d   = GRANT;
          gnt_idx_d = win_idx_s;
          gnt_d     = ONE_HOT_0 << win_idx_s;
          cnt_d     = '0;
        end else begin
          gnt_d = '0;
        end
      end
      GRANT: begin
        // A completed burst and a dropped request release identically.
        if (pop_s && !last_s) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d  = IDLE;
          gnt_d    = '0;
          rr_ptr_d = (gnt_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : (gnt_idx_q + IDX_W'(1));
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q     <= IDLE;
      gnt_idx_q   <= '0;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      gnt_idx_q   <= gnt_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
    end
  end

  assign gnt       = gnt_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign busy      = (state_q == GRANT);

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Bench for fifo_rd_arbiter: a queue stands in for the FIFO, a transaction-level
// model (owner / burst count / next-first index) predicts every cycle.
module tb_fifo_rd_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int IW = 2;

  logic          rclk = 1'b0;
  logic          rrst_n = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_rdata = '0;
  logic          fifo_rinc;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  gnt;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_id;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] fq[$];

  // reference model: owner (-1 when nobody holds the port), pops in burst, next first index
  int            m_owner;
  int            m_cnt;
  int            m_next;
  bit            m_ov;
  logic [DW-1:0] m_od;
  int            m_oid;

  logic [N-1:0]  prev_gnt;
  logic [N-1:0]  gnt_seq[$];
  int            ids_seen[$];
  int            rinc_seen, gnt_seen, busy_seen;
  logic [N-1:0]  obs_gnt;
  logic          obs_rinc, obs_ov;
  logic [DW-1:0] obs_od;
  logic [IW-1:0] obs_oid;

  typedef struct {
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic          rinc;
    logic          ov;
    logic [DW-1:0] od;
    logic [IW-1:0] oid;
  } vec_t;
  vec_t tbl[6];

  always #5 rclk = ~rclk;

  fifo_rd_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
    .fifo_rinc(fifo_rinc), .req(req), .gnt(gnt), .out_valid(out_valid),
    .out_data(out_data), .out_id(out_id), .busy(busy)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_pop();
    if (m_owner < 0) return 1'b0;
    return req[m_owner] && (fq.size() > 0);
  endfunction

  function automatic logic [N-1:0] exp_gnt();
    if (m_owner < 0) return '0;
    return N'(1) << m_owner;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_cnt   = 0;
    m_next  = 0;
    m_ov    = 1'b0;
    m_od    = '0;
    m_oid   = 0;
  endtask

  task automatic obs_clear();
    gnt_seq.delete();
    ids_seen.delete();
    rinc_seen = 0;
    gnt_seen  = 0;
    busy_seen = 0;
    prev_gnt  = '0;
  endtask

  task automatic model_step();
    bit p;
    p    = m_pop();
    m_ov = p;
    if (p) begin
      m_od  = fq.pop_front();
      m_oid = m_owner;
    end
    if (m_owner < 0) begin
      if (fq.size() > 0 && req != '0) begin
        for (int k = 0; k < N; k++) begin
          if (req[(m_next + k) % N]) begin
            m_owner = (m_next + k) % N;
            break;
          end
        end
        m_cnt = 0;
      end
    end else if (p && (m_cnt + 1 < MB)) begin
      m_cnt++;
    end else begin
      m_next  = (m_owner + 1) % N;
      m_owner = -1;
    end
  endtask

  // one clock: present FIFO head, check everything just after the negedge, advance the model at posedge
  task automatic cycle();
    fifo_empty = (fq.size() == 0);
    fifo_rdata = fifo_empty ? '0 : fq[0];
    #1;
    chk("gnt", gnt, exp_gnt());
    chk("busy", busy, (m_owner >= 0));
    chk("fifo_rinc", fifo_rinc, m_pop());
    chk("out_valid", out_valid, m_ov);
    chk("out_data", out_data, m_od);
    chk("out_id", out_id, m_oid);
    chk("rr_ptr", dut.rr_ptr_q, m_next);
    if (out_valid) ids_seen.push_back(out_id);
    if (fifo_rinc) rinc_seen++;
    if (gnt != '0) gnt_seen++;
    if (busy) busy_seen++;
    if (gnt != '0 && prev_gnt == '0) gnt_seq.push_back(gnt);
    prev_gnt = gnt;
    obs_gnt  = gnt;
    obs_rinc = fifo_rinc;
    obs_ov   = out_valid;
    obs_od   = out_data;
    obs_oid  = out_id;
    @(posedge rclk);
    model_step();
    @(negedge rclk);
  endtask

  task automatic do_reset();
    rrst_n = 1'b0;
    req    = '0;
    fq.delete();
    model_reset();
    obs_clear();
    #2;
    rrst_n = 1'b1;
  endtask

  initial begin
    tbl[0] = '{req: 4'b0100, gnt: 4'b0000, rinc: 1'b0, ov: 1'b0, od: 8'h00, oid: 2'd0};
    tbl[1] = '{req: 4'b0100, gnt: 4'b0100, rinc: 1'b1, ov: 1'b0, od: 8'h00, oid: 2'd0};
    tbl[2] = '{req: 4'b0100, gnt: 4'b0100, rinc: 1'b1, ov: 1'b1, od: 8'h11, oid: 2'd2};
    tbl[3] = '{req: 4'b0100, gnt: 4'b0100, rinc: 1'b1, ov: 1'b1, od: 8'h22, oid: 2'd2};
    tbl[4] = '{req: 4'b0100, gnt: 4'b0100, rinc: 1'b0, ov: 1'b1, od: 8'h33, oid: 2'd2};
    tbl[5] = '{req: 4'b0100, gnt: 4'b0000, rinc: 1'b0, ov: 1'b0, od: 8'h33, oid: 2'd2};

    model_reset();
    obs_clear();
    // reset values with FIFO non-empty and all requests high
    fq = '{8'h5A};
    fifo_empty = 1'b0;
    fifo_rdata = 8'h5A;
    req = 4'b1111;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_id", out_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fifo_rinc", fifo_rinc, 0);
    chk("rst_rr_ptr", dut.rr_ptr_q, 0);
    @(negedge rclk);

    // single requester, table-driven
    do_reset();
    fq = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 6; i++) begin
      req = tbl[i].req;
      cycle();
      chk($sformatf("t1_gnt[%0d]", i), obs_gnt, tbl[i].gnt);
      chk($sformatf("t1_rinc[%0d]", i), obs_rinc, tbl[i].rinc);
      chk($sformatf("t1_ov[%0d]", i), obs_ov, tbl[i].ov);
      chk($sformatf("t1_od[%0d]", i), obs_od, tbl[i].od);
      chk($sformatf("t1_oid[%0d]", i), obs_oid, tbl[i].oid);
    end
    chk("t1_rr_ptr", dut.rr_ptr_q, 3);

    // round robin over all four requesters
    do_reset();
    for (int i = 0; i < 20; i++) fq.push_back(DW'(i + 1));
    req = 4'b1111;
    repeat (26) cycle();
    chk("rr_words", ids_seen.size(), 20);
    chk("rr_grants", gnt_seq.size(), 5);
    for (int i = 0; i < 5 && i < gnt_seq.size(); i++)
      chk($sformatf("rr_gnt_seq[%0d]", i), gnt_seq[i], 1 << (i % 4));
    for (int i = 0; i < 16 && i < ids_seen.size(); i++)
      chk($sformatf("rr_id[%0d]", i), ids_seen[i], i / 4);

    // requester 1 drops after two pops
    do_reset();
    for (int i = 0; i < 6; i++) fq.push_back(DW'(8'hA0 + i));
    req = 4'b0010;
    repeat (3) cycle();
    req = 4'b0000;
    repeat (2) cycle();
    chk("drop_words", ids_seen.size(), 2);
    for (int i = 0; i < ids_seen.size(); i++) chk($sformatf("drop_id[%0d]", i), ids_seen[i], 1);
    chk("drop_rr_ptr", dut.rr_ptr_q, 2);
    chk("drop_left", fq.size(), 4);
    chk("drop_busy", busy, 0);

    // empty FIFO with stale requests
    do_reset();
    req = 4'b1111;
    repeat (10) cycle();
    chk("empty_gnt", gnt_seen, 0);
    chk("empty_rinc", rinc_seen, 0);
    chk("empty_busy", busy_seen, 0);

    // asynchronous reset after the second pop of a burst
    do_reset();
    for (int i = 0; i < 8; i++) fq.push_back(DW'(8'hC0 + i));
    req = 4'b0100;
    repeat (3) cycle();
    rrst_n = 1'b0;
    req = 4'b1111;
    model_reset();
    obs_clear();
    #1;
    chk("arst_gnt", gnt, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rr_ptr", dut.rr_ptr_q, 0);
    #1;
    rrst_n = 1'b1;
    repeat (3) cycle();
    chk("arst_restart_n", gnt_seq.size(), 1);
    if (gnt_seq.size() > 0) chk("arst_restart_gnt", gnt_seq[0], 1);

    // priority wrap from rr_ptr = 3
    do_reset();
    fq.push_back(8'hE7);
    req = 4'b0100;
    repeat (3) cycle();
    chk("wrap_rr_ptr", dut.rr_ptr_q, 3);
    for (int i = 0; i < 8; i++) fq.push_back(DW'(8'h70 + i));
    req = 4'b1001;
    repeat (10) cycle();
    chk("wrap_grants", gnt_seq.size(), 3);
    if (gnt_seq.size() > 2) begin
      chk("wrap_first", gnt_seq[1], 8);
      chk("wrap_second", gnt_seq[2], 1);
    end

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 1) == 1 && fq.size() < 12) fq.push_back(DW'($urandom));
      if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 15));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
